// File: rtl/add_seq_ctrl_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | add_seq_pkg : shared types and default sizes for add_seq_ctrl         |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package add_seq_pkg;

  localparam int DEFAULT_N     = 4;
  localparam int DEFAULT_WORDS = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/add_seq_ctrl_fanb.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | FANb : n-bit ripple-carry adder slice                                 |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module FANb #(
  parameter int n = 4
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         cin,
  output logic [n-1:0] s,
  output logic         cout
);

  logic [n:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < n; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[n];

endmodule
`default_nettype wire

// File: rtl/add_seq_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | add_seq_ctrl : multi-word add/sub sequencer over one shared N-bit     |
// | adder slice, LSB chunk first. Rev 1.0                                 |
// +-----------------------------------------------------------------------+
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int WORDS = DEFAULT_WORDS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [N*WORDS-1:0]   op_a,
  input  logic [N*WORDS-1:0]   op_b,
  input  logic                 cin,
  input  logic                 sub,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [N*WORDS-1:0]   sum,
  output logic                 cout,
  output logic                 overflow,
  output logic                 busy
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t          state, state_nxt;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    a_q, b_q, sum_q;
  logic            cout_q, ovf_q;

  logic [N-1:0]    slice_a, slice_b, slice_s;
  logic            slice_cout;
  logic            last;

  assign slice_a = a_q[idx*N +: N];
  assign slice_b = b_q[idx*N +: N];
  assign last    = (idx == LAST_IDX);

  FANb #(.n(N)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid) state_nxt = RUN;
      RUN:     if (last)        state_nxt = DONE;
      DONE:    if (res_ready)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // b is stored pre-inverted for subtract so RUN never needs to know the op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_q    <= op_a;
            b_q    <= sub ? ~op_b : op_b;
            carry  <= sub ? 1'b1 : cin;
            idx    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
          end
        end
        RUN: begin
          sum_q[idx*N +: N] <= slice_s;
          carry             <= slice_cout;
          if (last) begin
            cout_q <= slice_cout;
            ovf_q  <= (a_q[W-1] == b_q[W-1]) && (slice_s[N-1] != a_q[W-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);
  assign sum         = sum_q;
  assign cout        = cout_q;
  assign overflow    = ovf_q;

endmodule
`default_nettype wire

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
- Multi-word add/subtract sequencer built around one narrow N-bit ripple adder slice (FANb).
- Accepts a WORDS*N-bit operand pair through a valid/ready handshake.
- Feeds the operands to the slice one N-bit chunk per cycle, LSB chunk first, chaining cout back to cin.
- Presents the full-width result with carry and signed overflow through a second valid/ready handshake.

Parameters:
- N, 4, width of the shared adder slice in bits
- WORDS, 4, number of chunks per operation (W = N*WORDS, default 16)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start_valid  in  1  operand request valid
- start_ready  out  1  controller can accept a request
- op_a  in  W  operand A
- op_b  in  W  operand B
- cin  in  1  carry-in for add; ignored when sub=1
- sub  in  1  0: A+B+cin; 1: A-B, computed as A+~B+1
- res_valid  out  1  result valid
- res_ready  in  1  consumer accepts the result
- sum  out  W  result
- cout  out  1  carry out of the MSB chunk; for sub, 1 means no borrow
- overflow  out  1  two's-complement overflow of the W-bit result
- busy  out  1  high in RUN or DONE

Behaviour:
- One clock domain. All state registers reset asynchronously when rst=1.
- States: IDLE, RUN, DONE.
- Reset values: state=IDLE, chunk index=0, carry reg=0, sum=0, cout=0, overflow=0, res_valid=0, busy=0. start_ready=1 while in IDLE, including during reset.
- start_ready=1 only in IDLE. res_valid=1 only in DONE.
- IDLE → RUN on start_valid && start_ready. On that edge the block:
  - latches op_a, and b_eff = sub ? ~op_b : op_b;
  - sets carry = sub ? 1 : cin;
  - sets index = 0;
  - clears sum, cout and overflow.
- RUN, each cycle: the slice receives a = A[idx*N +: N], b = b_eff[idx*N +: N], cin = carry.
  - On the edge: sum[idx*N +: N] <= s, carry <= slice cout, idx <= idx+1.
  - When idx == WORDS-1: cout <= slice cout, overflow <= (A[W-1] == b_eff[W-1]) && (s[N-1] != A[W-1]), and the state goes to DONE.
- Latency: res_valid rises exactly WORDS clock edges after the accepting edge.
- DONE: sum, cout and overflow are held stable while res_valid=1 && res_ready=0. This state has no timeout.
- DONE → IDLE on res_ready=1. There is one IDLE cycle (one bubble) before the next accept. Throughput is one operation per WORDS+2 cycles with res_ready tied high.
- After DONE the outputs keep the last result until the next accept clears them.
- start_valid in RUN or DONE is ignored. Operand inputs are sampled only on the accepting edge; changes afterwards have no effect.
- res_ready in IDLE or RUN is ignored.
- rst asserted in any state aborts the operation. All registers return to reset values immediately (asynchronously). No partial result is ever flagged valid.
- WORDS=1: RUN lasts one cycle. The behaviour is otherwise identical.
- Index counter width is $clog2(WORDS) with a minimum of 1. The index never wraps past WORDS-1.

Decomposition:
- Package add_seq_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - default constants for N and WORDS.
- One sub-module is natural: the existing n-parameterised adder FANb, instantiated once as the shared slice with n=N.
- The controller owns all muxing of chunks into the slice and all carry chaining.

Test Plan (N=4, WORDS=4, res_ready=1 unless stated):
1. op_a=16'h00FF, op_b=16'h0001, cin=0, sub=0 → 4 edges after accept: res_valid=1, sum=16'h0100, cout=0, overflow=0.
2. op_a=16'hFFFF, op_b=16'h0000, cin=1, sub=0 → sum=16'h0000, cout=1, overflow=0. Full carry ripples through all chunks.
3. op_a=16'h0005, op_b=16'h0009, sub=1, cin=1 (ignored) → sum=16'hFFFC, cout=0 (borrow), overflow=0. Also op_a=16'h8000, op_b=16'h0001, sub=1 → sum=16'h7FFF, cout=1, overflow=1.
4. op_a=16'h7FFF, op_b=16'h0001, sub=0 → sum=16'h8000, cout=0, overflow=1.
5. Backpressure: hold res_ready=0 for 10 cycles after res_valid; pulse start_valid and change the operands meanwhile → res_valid, sum, cout and overflow stay constant, start_ready=0, busy=1. Then raise res_ready → IDLE for one cycle; the next start_valid is accepted on the following edge.
6. Assert rst asynchronously between clock edges two cycles into RUN → immediately start_ready=1, res_valid=0, busy=0, sum=0, cout=0, overflow=0. A fresh request after release completes correctly (repeat scenario 1).
